bus_arbiter_mux: RTL and testbench

Parametrised bus arbiter plus master multiplexer for N bus masters: round-robin arbitration, registered active-low grants, and an optional tenure limit that hands the bus to a waiting master. Sits between the masters and the shared bus in the bus subsystem. Drives the shared address/control/write-data lines from the current owner and parks them at defaults when the bus is idle.

---
 rtl/bus_arbiter_mux_pkg.sv | 26 ++
 rtl/bus_rr_select.sv | 29 ++
 rtl/bus_arbiter_mux.sv | 158 +++++++++++++++
 tb/tb_bus_arbiter_mux.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_mux_pkg.sv
// Bus subsystem header: shared bus constants, arbiter FSM encodings and a
// small index helper used by the round-robin search.

`ifndef BUS_DEFS_SVH
`define BUS_DEFS_SVH
`define ENABLE_     1'b0
`define DISABLE_    1'b1
`define READ        1'b1
`define WRITE       1'b0
`define ADDR_WIDTH  16
`define DATA_WIDTH  16
`endif

package bus_arbiter_mux_pkg;

   // Arbiter FSM encodings (kept as plain constants for older tools).
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OWNED = 1'b1;

   // Position reached by stepping 'off' places forward from 'base' on a
   // ring of 'n' masters.
   function automatic int wrap_idx(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/bus_rr_select.sv
// Round-robin search: starting just after 'last' and wrapping, return the
// first asserted request (active-high) and whether any request was found.

module bus_rr_select
   import bus_arbiter_mux_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic             found,
   output logic [IDX_W-1:0] next_idx
);

   // Walk the ring from farthest to nearest so the nearest requester after
   // 'last' is the one left standing.
   always_comb begin
      found    = 1'b0;
      next_idx = last;
      for (int off = N; off >= 1; off--) begin
         if (req[wrap_idx(int'(last), off, N)]) begin
            found    = 1'b1;
            next_idx = IDX_W'(wrap_idx(int'(last), off, N));
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Round-robin bus arbiter with registered active-low grants, optional tenure
// limit, and the master-to-shared-bus multiplexer.

module bus_arbiter_mux
   import bus_arbiter_mux_pkg::*;
#(
   parameter int N_MASTERS  = 4,
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int MAX_HOLD   = 0
) (
   input  logic                             clk,
   input  logic                             reset_,
   input  logic [N_MASTERS-1:0]             m_req_,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
   input  logic [N_MASTERS-1:0]             m_as_,
   input  logic [N_MASTERS-1:0]             m_rw,
   input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wr_data,
   output logic [N_MASTERS-1:0]             m_grnt_,
   output logic [$clog2(N_MASTERS)-1:0]     owner,
   output logic                             bus_busy,
   output logic [ADDR_WIDTH-1:0]            out_addr,
   output logic                             out_as_,
   output logic                             out_rw,
   output logic [DATA_WIDTH-1:0]            out_wr_data
);

   localparam int IDX_W  = $clog2(N_MASTERS);
   localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   logic [0:0]           state, state_nxt;
   logic [IDX_W-1:0]     last, last_nxt;
   logic [IDX_W-1:0]     owner_nxt;
   logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
   logic [N_MASTERS-1:0] grnt_nxt;

   logic [N_MASTERS-1:0] req;
   logic [N_MASTERS-1:0] owner_mask;
   logic [N_MASTERS-1:0] cand;
   logic                 found;
   logic [IDX_W-1:0]     sel_idx;
   logic                 owner_req;
   logic                 owner_as_;
   logic                 hold_full;
   logic                 grant_move;

   assign req       = ~m_req_;
   assign bus_busy  = (state == ST_OWNED);
   assign owner_req = req[owner];
   assign owner_as_ = m_as_[owner];
   assign hold_full = (MAX_HOLD > 0) && (hold_cnt == HOLD_W'(MAX_HOLD));
   assign cand      = req & ~owner_mask;

   // The current owner is excluded from the search so preemption and
   // release always pick a different master.
   always_comb begin
      owner_mask = '0;
      if (state == ST_OWNED) begin
         owner_mask[owner] = 1'b1;
      end
   end

   bus_rr_select #(
      .N     (N_MASTERS),
      .IDX_W (IDX_W)
   ) u_rr_select (
      .req      (cand),
      .last     (last),
      .found    (found),
      .next_idx (sel_idx)
   );

   // Next-state decision: grant from idle, handover on release, tenure
   // preemption only between strobes, otherwise keep counting tenure.
   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      last_nxt   = last;
      hold_nxt   = hold_cnt;
      grant_move = 1'b0;

      case (state)
         ST_IDLE: begin
            hold_nxt = '0;
            if (found) begin
               grant_move = 1'b1;
            end
         end
         ST_OWNED: begin
            if (!owner_req) begin
               if (found) begin
                  grant_move = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
                  hold_nxt  = '0;
               end
            end else if (hold_full && found && owner_as_) begin
               grant_move = 1'b1;
            end else if ((MAX_HOLD > 0) && !hold_full) begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            hold_nxt  = '0;
         end
      endcase

      if (grant_move) begin
         state_nxt = ST_OWNED;
         owner_nxt = sel_idx;
         last_nxt  = sel_idx;
         hold_nxt  = '0;
      end
   end

   // Grant vector is one-cold on the next owner, or all high when idle.
   always_comb begin
      grnt_nxt = '1;
      if (state_nxt == ST_OWNED) begin
         grnt_nxt[owner_nxt] = 1'b0;
      end
   end

   // Arbiter state; reset parks the pointer on the last master so master 0
   // wins the first search.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state    <= ST_IDLE;
         m_grnt_  <= '1;
         owner    <= '0;
         last     <= IDX_W'(N_MASTERS - 1);
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         m_grnt_  <= grnt_nxt;
         owner    <= owner_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // Shared bus follows the owner's lines directly; idle parks at defaults
   // so no ungranted strobe can reach the bus.
   always_comb begin
      out_addr    = '0;
      out_as_     = `DISABLE_;
      out_rw      = `READ;
      out_wr_data = '0;
      if (bus_busy) begin
         out_addr    = m_addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
         out_as_     = m_as_[owner];
         out_rw      = m_rw[owner];
         out_wr_data = m_wr_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux (4 masters, tenure limit 4) with a
// queue-based scoreboard checked on the falling clock edge.

module tb_bus_arbiter_mux;

   localparam int NM = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic              clk;
   logic              reset_;
   logic [NM-1:0]     m_req_;
   logic [NM*AW-1:0]  m_addr;
   logic [NM-1:0]     m_as_;
   logic [NM-1:0]     m_rw;
   logic [NM*DW-1:0]  m_wr_data;
   logic [NM-1:0]     m_grnt_;
   logic [1:0]        owner;
   logic              bus_busy;
   logic [AW-1:0]     out_addr;
   logic              out_as_;
   logic              out_rw;
   logic [DW-1:0]     out_wr_data;

   typedef struct {
      int          step;
      logic [3:0]  grnt;
      logic        busy;
      int          own;
      logic [15:0] addr;
      logic        as_n;
      logic        rw;
      logic [15:0] wdata;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nerr = 0;
   int   step = 0;

   bus_arbiter_mux #(
      .N_MASTERS  (NM),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MAX_HOLD   (4)
   ) dut (
      .clk         (clk),
      .reset_      (reset_),
      .m_req_      (m_req_),
      .m_addr      (m_addr),
      .m_as_       (m_as_),
      .m_rw        (m_rw),
      .m_wr_data   (m_wr_data),
      .m_grnt_     (m_grnt_),
      .owner       (owner),
      .bus_busy    (bus_busy),
      .out_addr    (out_addr),
      .out_as_     (out_as_),
      .out_rw      (out_rw),
      .out_wr_data (out_wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] addr_of(input int i);
      return 16'hA000 + 16'(i) * 16'h0111;
   endfunction

   function automatic logic [15:0] data_of(input int i);
      return 16'h5000 + 16'(i) * 16'h0101;
   endfunction

   task automatic cmp(input string nm, input int stp, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s (step %0d): got %0h, want %0h", nm, stp, act, exp);
      end
   endtask

   // Queue the expected view of the current cycle. Shared-bus values come
   // from the hand-chosen owner and the inputs driven this cycle.
   task automatic push(input logic [3:0] g, input logic b, input int own);
      exp_t e;
      e.step = step;
      e.grnt = g;
      e.busy = b;
      e.own  = own;
      if (b) begin
         e.addr  = addr_of(own);
         e.as_n  = m_as_[own];
         e.rw    = m_rw[own];
         e.wdata = data_of(own);
      end else begin
         e.addr  = 16'h0000;
         e.as_n  = 1'b1;
         e.rw    = 1'b1;
         e.wdata = 16'h0000;
      end
      q.push_back(e);
      step++;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         cmp("m_grnt_",     e.step, 32'(m_grnt_),     32'(e.grnt));
         cmp("bus_busy",    e.step, 32'(bus_busy),    32'(e.busy));
         cmp("out_addr",    e.step, 32'(out_addr),    32'(e.addr));
         cmp("out_as_",     e.step, 32'(out_as_),     32'(e.as_n));
         cmp("out_rw",      e.step, 32'(out_rw),      32'(e.rw));
         cmp("out_wr_data", e.step, 32'(out_wr_data), 32'(e.wdata));
         if (e.busy) begin
            cmp("owner", e.step, 32'(owner), 32'(e.own));
            if (e.own == 1 && m_as_[3] == 1'b0) begin
               cmp("no_strobe_leak", e.step, 32'(out_as_), 32'(m_as_[1]));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      reset_ = 1'b0;
      m_req_ = 4'hF;
      m_as_  = 4'hF;
      m_rw   = 4'b0101;
      for (int i = 0; i < NM; i++) begin
         m_addr[i*AW +: AW]    = addr_of(i);
         m_wr_data[i*DW +: DW] = data_of(i);
      end

      // Held in reset: idle defaults.
      adv();
      push(4'hF, 1'b0, 0);

      // Release reset with masters 0 and 2 requesting: master 0 wins.
      adv();
      reset_ = 1'b1;
      m_req_ = 4'b1010;
      push(4'hF, 1'b0, 0);
      adv();
      m_as_ = 4'b1110;
      push(4'b1110, 1'b1, 0);

      // Master 0 releases while 2 and 3 request: 2 next, no idle cycle.
      adv();
      m_req_ = 4'b0011;
      m_as_  = 4'hF;
      push(4'b1110, 1'b1, 0);

      // Master 2 owns and releases at once; only master 1 is waiting.
      adv();
      m_req_ = 4'b1101;
      push(4'b1011, 1'b1, 2);

      // Master 1 holds with strobe high; master 3 waits with its strobe low.
      adv();
      m_req_ = 4'b0101;
      m_as_  = 4'b0111;
      push(4'b1101, 1'b1, 1);
      for (int k = 0; k < 4; k++) begin
         adv();
         push(4'b1101, 1'b1, 1);
      end

      // Tenure expired: master 3 owns, then releases with only 1 waiting
      // (search wraps 3 -> 0 -> 1).
      adv();
      m_req_ = 4'b1101;
      m_as_  = 4'hF;
      push(4'b0111, 1'b1, 3);

      // Master 1 again, strobe low for 3 cycles after tenure is reached.
      adv();
      m_req_ = 4'b0101;
      push(4'b1101, 1'b1, 1);
      for (int k = 0; k < 3; k++) begin
         adv();
         push(4'b1101, 1'b1, 1);
      end
      for (int k = 0; k < 3; k++) begin
         adv();
         m_as_ = 4'b1101;
         push(4'b1101, 1'b1, 1);
      end
      adv();
      m_as_ = 4'hF;
      push(4'b1101, 1'b1, 1);

      // Preemption lands only after the strobe rose; then all release.
      adv();
      m_req_ = 4'hF;
      push(4'b0111, 1'b1, 3);

      // Idle defaults; master 2 requests next (pointer at 3 -> 0,1,2).
      adv();
      m_req_ = 4'b1011;
      push(4'hF, 1'b0, 0);
      adv();
      m_as_ = 4'b1011;
      push(4'b1011, 1'b1, 2);

      // Asynchronous reset mid-access: grants drop with no clock edge.
      adv();
      reset_ = 1'b0;
      #1;
      cmp("async_grnt", step, 32'(m_grnt_),  32'hF);
      cmp("async_busy", step, 32'(bus_busy), 32'h0);
      cmp("async_as_",  step, 32'(out_as_),  32'h1);
      cmp("async_addr", step, 32'(out_addr), 32'h0);
      push(4'hF, 1'b0, 0);
      adv();
      m_req_ = 4'b1010;
      m_as_  = 4'hF;
      push(4'hF, 1'b0, 0);

      // After reset, master 0 beats master 2 again.
      adv();
      reset_ = 1'b1;
      push(4'hF, 1'b0, 0);
      adv();
      push(4'b1110, 1'b1, 0);
      adv();
      m_req_ = 4'hF;
      push(4'b1110, 1'b1, 0);
      adv();
      push(4'hF, 1'b0, 0);

      // Let the monitor drain the queue within a bounded number of cycles.
      for (int k = 0; k < 10; k++) begin
         if (q.size() == 0) break;
         @(negedge clk);
      end
      #1;
      cmp("queue_drained", step, 32'(q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
